// File: rtl/avmm_block_reader_if.sv
// Avalon-MM read bus plus valid/ready output stream used by avmm_block_reader.
// The master modport is the reader side; the slave modport is the memory/sink side.
interface avmm_block_reader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata;

    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    modport master (
        output avm_address, avm_chipselect, avm_write, avm_byteenable,
        input  avm_readdata,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_byteenable,
        output avm_readdata,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface

// File: rtl/avmm_block_reader.sv
// Avalon-MM block reader: streams word_count words from a fixed-latency RAM with SOP/EOP framing.
// Optional continuous looping is enabled with the AVMM_BLOCK_READER_LOOP_EN macro.
module avmm_block_reader #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                abort,
`ifdef AVMM_BLOCK_READER_LOOP_EN
    input  logic                loop,
`endif
    output logic                busy,
    output logic                done,
    avmm_block_reader_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);
    localparam int ENT_W = DATA_W + 2;

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [ADDR_W:0]         rem_q, rem_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic                    loop_q, loop_d;
    logic                    done_q, done_d;

    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_sop_q, pipe_sop_d;
    logic [READ_LATENCY-1:0] pipe_eop_q, pipe_eop_d;

    logic [ENT_W-1:0]        fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]        fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          fifo_cnt_q, fifo_cnt_d;

    logic                    loop_in;
    logic [CNT_W-1:0]        inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [ENT_W-1:0]        head;
    logic                    flush;

`ifdef AVMM_BLOCK_READER_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign head         = fifo_mem_q[rd_ptr_q];
    assign bus.st_valid = (fifo_cnt_q != '0);
    assign bus.st_data  = head[DATA_W-1:0];
    assign bus.st_sop   = bus.st_valid & head[DATA_W];
    assign bus.st_eop   = bus.st_valid & head[DATA_W+1];

    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = issue;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = '1;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    // Credit rule: a read is only issued if its return is guaranteed a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
        issue = (state_q == S_ISSUE) && ((CNT_W'(fifo_cnt_q) + inflight) < DEPTH_V);
        push  = pipe_vld_q[READ_LATENCY-1];
        pop   = bus.st_valid & bus.st_ready;
        flush = abort && (state_q != S_IDLE);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        rem_d   = rem_q;
        count_d = count_q;
        loop_d  = loop_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    base_d  = base_addr;
                    addr_d  = base_addr;
                    count_d = word_count;
                    rem_d   = word_count;
                    loop_d  = loop_in;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        if (loop_q) begin
                            addr_d = base_q;
                            rem_d  = count_q;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (pop && head[DATA_W+1] && (state_q != S_IDLE)) begin
            done_d = 1'b1;
            if (state_q == S_DRAIN) begin
                state_d = S_IDLE;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // Issue tags ride the latency pipeline so framing stays correct across looped blocks.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_sop_d    = '0;
        pipe_eop_d    = '0;
        pipe_vld_d[0] = issue;
        pipe_sop_d[0] = issue && (rem_q == count_q);
        pipe_eop_d[0] = issue && (rem_q == (ADDR_W+1)'(1));
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_sop_d[i] = pipe_sop_q[i-1];
            pipe_eop_d[i] = pipe_eop_q[i-1];
        end

        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {pipe_eop_q[READ_LATENCY-1], pipe_sop_q[READ_LATENCY-1],
                                    bus.avm_readdata};
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        if (flush) begin
            pipe_vld_d = '0;
            pipe_sop_d = '0;
            pipe_eop_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            rem_q      <= '0;
            count_q    <= '0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            pipe_vld_q <= '0;
            pipe_sop_q <= '0;
            pipe_eop_q <= '0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            count_q    <= count_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_sop_q <= pipe_sop_d;
            pipe_eop_q <= pipe_eop_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_avmm_block_reader.sv
// Scoreboard bench for avmm_block_reader against a latency-1 RAM model.
module tb_avmm_block_reader;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              abort;
    logic              busy;
    logic              done;

    avmm_block_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avmm_block_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .abort(abort),
`ifdef AVMM_BLOCK_READER_LOOP_EN
        .loop(1'b0),
`endif
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]       mem [1 << ADDR_W];
    logic [ADDR_W-1:0] rd_addr;
    always @(posedge clk) if (bus.avm_chipselect) rd_addr <= bus.avm_address;
    assign bus.avm_readdata = mem[rd_addr];

    int n_checks = 0;
    int n_fail   = 0;
    logic [33:0] sb [$];
    int cyc = 0;
    int beats = 0;
    int issued = 0;
    int accepted = 0;
    int done_count = 0;
    int valid_cycles = 0;
    int cs_cycles = 0;
    int eop_cyc = 0;
    bit zero_mode = 0;
    bit ready_mode = 0;
    bit prev_stall = 0;
    bit prev_abort = 0;
    logic [33:0] prev_beat;
    logic [33:0] exp_beat;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            logic [ADDR_W-1:0] a;
            a = base + ADDR_W'(i);
            sb.push_back({(i == count - 1), (i == 0), 32'hA500_0000 + 32'(a)});
        end
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = (ADDR_W+1)'(count);
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= budget) checkOutput({tag, "_timeout"}, 0, 1);
        else begin
            checkOutput({tag, "_busy_at_done"}, busy, 0);
            checkOutput({tag, "_sb_empty"}, sb.size(), 0);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        st_ready_init();
        forever begin
            @(posedge clk); #1;
            bus.st_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic st_ready_init();
        bus.st_ready = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every accepted beat and tracks bus activity.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.avm_chipselect) begin
                issued++;
                cs_cycles++;
            end
            if (bus.st_valid) valid_cycles++;
            if (bus.st_valid && bus.st_ready) begin
                accepted++;
                beats++;
                if (sb.size() == 0) checkOutput("unexpected_beat", 1, 0);
                else begin
                    exp_beat = sb.pop_front();
                    checkOutput("st_data", bus.st_data, exp_beat[31:0]);
                    checkOutput("st_sop", bus.st_sop, exp_beat[32]);
                    checkOutput("st_eop", bus.st_eop, exp_beat[33]);
                end
                if (bus.st_eop) eop_cyc = cyc;
            end
            if (bus.avm_chipselect)
                checkOutput("outstanding", ((issued - accepted) <= FIFO_DEPTH) ? 1 : 0, 1);
            if (prev_stall && !prev_abort)
                checkOutput("stall_hold", {bus.st_valid, bus.st_eop, bus.st_sop, bus.st_data},
                            {1'b1, prev_beat});
            if (done) begin
                done_count++;
                if (!zero_mode) checkOutput("done_after_eop", cyc - eop_cyc, 1);
            end
        end
        if (abort || !reset_n) accepted = issued;
        prev_stall = reset_n && bus.st_valid && !bus.st_ready;
        prev_beat  = {bus.st_eop, bus.st_sop, bus.st_data};
        prev_abort = abort;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic singleRead(input string tag);
        int n;
        applyStimulus(13'h10, 8);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.st_valid) break;
            n++;
        end
        checkOutput({tag, "_first_valid_lat"}, n, 2);
        waitDone(tag, 100);
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int d0, v0, c0, b0, n;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 + 32'(i);
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_cs", bus.avm_chipselect, 0);
        checkOutput("rst_addr", bus.avm_address, 0);
        checkOutput("rst_valid", bus.st_valid, 0);
        checkOutput("rst_data", bus.st_data, 0);
        checkOutput("rst_sop_eop", {bus.st_sop, bus.st_eop}, 0);
        checkOutput("rst_write", bus.avm_write, 0);
        checkOutput("rst_byteen", bus.avm_byteenable, 4'hF);
        @(posedge clk); #1 reset_n = 1'b1;

        $display("[TB] single read");
        singleRead("single");

        $display("[TB] backpressure");
        ready_mode = 1;
        applyStimulus(13'h40, 16);
        waitDone("bp", 400);
        ready_mode = 0;

        $display("[TB] wrap");
        applyStimulus(13'h1FFE, 4);
        waitDone("wrap", 100);

        $display("[TB] zero count");
        zero_mode = 1;
        v0 = valid_cycles; c0 = cs_cycles;
        applyStimulus(13'h20, 0);
        waitDone("zero", 10);
        repeat (3) @(negedge clk);
        checkOutput("zero_cs", cs_cycles - c0, 0);
        checkOutput("zero_valid", valid_cycles - v0, 0);
        zero_mode = 0;

        $display("[TB] one word");
        applyStimulus(13'h33, 1);
        waitDone("one", 50);

        $display("[TB] abort");
        b0 = beats;
        applyStimulus(13'h100, 32);
        n = 0;
        while (beats < b0 + 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("abort_reach5", (beats >= b0 + 5) ? 1 : 0, 1);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        sb.delete();
        d0 = done_count;
        @(negedge clk);
        checkOutput("abort_cs", bus.avm_chipselect, 0);
        checkOutput("abort_valid", bus.st_valid, 0);
        checkOutput("abort_busy", busy, 0);
        v0 = valid_cycles;
        repeat (10) @(negedge clk);
        checkOutput("abort_no_done", done_count - d0, 0);
        checkOutput("abort_no_valid", valid_cycles - v0, 0);
        applyStimulus(13'h0, 2);
        waitDone("post_abort", 50);

        $display("[TB] reset mid-transfer");
        applyStimulus(13'h200, 16);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_cs", bus.avm_chipselect, 0);
        checkOutput("arst_addr", bus.avm_address, 0);
        checkOutput("arst_valid", bus.st_valid, 0);
        checkOutput("arst_data", bus.st_data, 0);
        checkOutput("arst_sop_eop", {bus.st_sop, bus.st_eop}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        singleRead("after_rst");

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
